// File: rtl/rmt_pkg.sv
// rtl/rmt_pkg.sv - shared constants and helpers for the RMT pipeline blocks
// Contents:
//   PHV_LEN : default PHV width in bits
//   level_w : width of an occupancy counter able to hold 0..depth
package rmt_pkg;

  localparam int PHV_LEN = 1124;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/phv_ram.sv
// rtl/phv_ram.sv - simple dual-port PHV storage with one registered read port
// Ports:
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : word to store
//   rd_en   : read strobe, rd_data loads mem[rd_addr] on the rising edge
//   rd_addr : read address
//   rd_data : registered read data, held while rd_en=0
module phv_ram #(
  parameter int WIDTH = 1124,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/phv_fifo_n.sv
// rtl/phv_fifo_n.sv - first-word-fall-through PHV FIFO between the last stage and the deparser
// Ports:
//   clk, srst       : clock, synchronous active-high reset
//   phv_in          : PHV from the last stage
//   phv_in_valid    : write strobe
//   stage_ready_out : registered almost-full back-pressure (1 = may send)
//   phv_fifo_out    : head PHV, valid while phv_fifo_empty=0
//   phv_fifo_empty  : head not valid
//   phv_fifo_rd_en  : pop request from the deparser
//   level           : stored PHV count, head included
//   max_level       : high-watermark of level
//   drop_cnt        : saturating count of rejected writes
//   overflow        : sticky, set by the first rejected write
module phv_fifo_n
  import rmt_pkg::*;
#(
  parameter int PHV_WIDTH = PHV_LEN,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic [PHV_WIDTH-1:0]          phv_in,
  input  logic                          phv_in_valid,
  output logic                          stage_ready_out,
  output logic [PHV_WIDTH-1:0]          phv_fifo_out,
  output logic                          phv_fifo_empty,
  input  logic                          phv_fifo_rd_en,
  output logic [level_w(DEPTH)-1:0]     level,
  output logic [level_w(DEPTH)-1:0]     max_level,
  output logic [31:0]                   drop_cnt,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] READY_LIM = LW'(DEPTH - AF_MARGIN + 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          head_valid;
  logic          wr_acc;
  logic          drop;
  logic          pop;
  logic          fetch;
  logic [LW-1:0] ram_cnt;
  logic [LW-1:0] level_nxt;

  // The RAM's registered read data is the head register: it only reloads on a
  // fetch, so the head stays stable until popped.
  phv_ram #(
    .WIDTH (PHV_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (phv_in),
    .rd_en   (fetch),
    .rd_addr (rd_ptr),
    .rd_data (phv_fifo_out)
  );

  assign phv_fifo_empty = ~head_valid;

  always_comb begin
    wr_acc    = 1'b0;
    drop      = 1'b0;
    pop       = 1'b0;
    fetch     = 1'b0;
    ram_cnt   = level - {{(LW-1){1'b0}}, head_valid};
    level_nxt = level;
    if (!srst) begin
      // A full FIFO rejects the write even when a pop frees a slot this cycle.
      wr_acc = phv_in_valid && (level != FULL_LVL);
      drop   = phv_in_valid && (level == FULL_LVL);
      pop    = phv_fifo_rd_en && head_valid;
      // Refill the head whenever it is (or is about to be) vacant and an
      // older entry is waiting in the RAM; same-cycle writes are not eligible.
      fetch  = (ram_cnt != '0) && (!head_valid || pop);
      case ({wr_acc, pop})
        2'b10:   level_nxt = level + 1'b1;
        2'b01:   level_nxt = level - 1'b1;
        default: level_nxt = level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      head_valid      <= 1'b0;
      level           <= '0;
      max_level       <= '0;
      drop_cnt        <= '0;
      overflow        <= 1'b0;
      stage_ready_out <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)  rd_ptr <= rd_ptr + 1'b1;
      if (fetch)
        head_valid <= 1'b1;
      else if (pop)
        head_valid <= 1'b0;
      level           <= level_nxt;
      stage_ready_out <= (level_nxt < READY_LIM);
      if (level_nxt > max_level) max_level <= level_nxt;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/phv_fifo_n.md
PHV_FIFO_N -- requirements
Module: phv_fifo_n

Interface
REQ-001 SHALL have parameter PHV_WIDTH, default 1124: width of one stored PHV in bits.
REQ-002 SHALL have parameter DEPTH, default 16: total PHV capacity, power of two, minimum 4.
REQ-003 SHALL have parameter AF_MARGIN, default 4: free slots kept in reserve for upstream stage skid; range 1..DEPTH-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-005 SHALL have port srst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port phv_in, input, PHV_WIDTH bits: PHV from the last stage.
REQ-007 SHALL have port phv_in_valid, input, 1 bit: single-cycle write strobe.
REQ-008 SHALL have port stage_ready_out, output, 1 bit: almost-full back-pressure to the stage (1 = may send).
REQ-009 SHALL have port phv_fifo_out, output, PHV_WIDTH bits: head PHV (first-word-fall-through).
REQ-010 SHALL have port phv_fifo_empty, output, 1 bit: 1 when phv_fifo_out is not valid.
REQ-011 SHALL have port phv_fifo_rd_en, input, 1 bit: pop head, from the deparser.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: stored PHV count.
REQ-013 SHALL have port max_level, output, $clog2(DEPTH)+1 bits: high-watermark of level.
REQ-014 SHALL have port drop_cnt, output, 32 bits: saturating count of rejected writes.
REQ-015 SHALL have port overflow, output, 1 bit: sticky, set on the first rejected write.

Function
REQ-016 SHALL store the full PHV_WIDTH bits per entry in one memory, with a single level/pointer set for the whole word; no split FIFOs.
REQ-017 SHALL accept a write when phv_in_valid=1 and level<DEPTH; when level==DEPTH it SHALL drop the write even if a pop occurs in the same cycle.
REQ-018 SHALL, on a dropped write, increment drop_cnt (holding at 32'hFFFFFFFF) and set overflow=1 in the next cycle.
REQ-019 SHALL count level as all stored PHVs, including the output register: +1 on accepted write, -1 on a pop, unchanged when both occur.
REQ-020 SHALL treat a pop as phv_fifo_rd_en=1 with phv_fifo_empty=0; phv_fifo_rd_en while empty SHALL be ignored with no state change.
REQ-021 SHALL use a read memory with registered output and a prefetch output register: a write in cycle N to an empty FIFO gives phv_fifo_empty=0 and valid phv_fifo_out in cycle N+2.
REQ-022 SHALL, when a pop occurs and further entries are stored, present the next PHV in the cycle after the pop (no bubble), so sustained one-pop-per-cycle throughput is possible.
REQ-023 SHALL hold phv_fifo_out stable while phv_fifo_empty=0 and no pop occurs.
REQ-024 SHALL register stage_ready_out = (next level < DEPTH-AF_MARGIN+1), i.e. deassert once level reaches DEPTH-AF_MARGIN+1.
REQ-025 SHALL wrap read and write pointers modulo DEPTH, with no special case at the wrap.
REQ-026 SHALL update max_level to level whenever level exceeds it.

Reset
REQ-027 SHALL, while srst=1, set level=0, max_level=0, drop_cnt=0, overflow=0, phv_fifo_empty=1, stage_ready_out=0, and both pointers to 0.
REQ-028 SHALL discard all stored PHVs on srst asserted mid-operation; memory contents need not be cleared.
REQ-029 SHALL set stage_ready_out=1 in the first cycle after srst deasserts.
REQ-030 SHALL ignore writes and pops in any cycle in which srst=1.

Structure
REQ-031 SHALL take the PHV_LEN default and the level width function from the shared rmt_pkg package.
REQ-032 SHALL place storage in one sub-module, phv_ram: a simple dual-port memory with DEPTH entries of PHV_WIDTH bits, one registered read port and one write port.
REQ-033 SHALL keep the pointers, level, prefetch control and statistics in phv_fifo_n.

Verification (PHV_WIDTH=1124, DEPTH=4, AF_MARGIN=1)
REQ-034 SHALL cover: after reset, write 0xA in cycle 0 -> phv_fifo_empty=0 and phv_fifo_out=0xA at cycle 2; level=1.
REQ-035 SHALL cover: write 1,2,3 on consecutive cycles -> stage_ready_out=1 after the 3rd write; write 4 -> level=4, stage_ready_out=0, max_level=4.
REQ-036 SHALL cover: at full, write 5 with rd_en in the same cycle -> 5 dropped, drop_cnt=1, overflow=1, level=3, pops return 2,3,4.
REQ-037 SHALL cover: continuous write and continuous rd_en for 20 cycles -> output sequence in order with no gaps after the first, level constant, pointers wrap 5 times.
REQ-038 SHALL cover: rd_en while empty -> level stays 0; srst with 3 stored PHVs -> phv_fifo_empty=1, level=0, drop_cnt=0 next cycle.
REQ-039 SHALL cover: drop_cnt preloaded via force to 32'hFFFFFFFE plus 3 drops -> drop_cnt holds 32'hFFFFFFFF.
